// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage.
package if_fetch_stage_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        FULL  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

    localparam int unsigned PC_STEP          = 4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/if_fetch_stage_skid.sv
// One-entry holding slot for a fetch response that arrives while IF/ID is stalled.
module fetch_skid_slot
    import if_fetch_stage_pkg::*;
#(
    parameter int unsigned PC_W    = 32,
    parameter int unsigned INSTR_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               unload,
    input  logic               clear,
    input  logic [PC_W-1:0]    load_pc,
    input  logic [INSTR_W-1:0] load_instr,
    output logic [PC_W-1:0]    pc,
    output logic [INSTR_W-1:0] instr,
    output logic               full
);

    // clear (redirect) dominates, then load, then unload
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc    <= '0;
            instr <= '0;
            full  <= 1'b0;
        end else if (clear) begin
            full  <= 1'b0;
        end else if (load) begin
            pc    <= load_pc;
            instr <= load_instr;
            full  <= 1'b1;
        end else if (unload) begin
            full  <= 1'b0;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, talks to a variable-latency imem,
// presents {pc, instr, valid} to IF/ID, honours stall and EX redirect.
//
// state | meaning
// BOOT  | first cycle after reset, no request yet
// FETCH | request outstanding at imem_addr_o
// FULL  | response parked in skid, waiting for IF/ID to free up
// DRAIN | redirected while a response was in flight; absorb and drop it
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter int unsigned     PC_W     = 32,
    parameter int unsigned     INSTR_W  = 32,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEFAULT)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall_i,
    input  logic               redirect_i,
    input  logic [PC_W-1:0]    redirect_pc_i,
    output logic               imem_req_o,
    output logic [PC_W-1:0]    imem_addr_o,
    input  logic [INSTR_W-1:0] imem_rdata_i,
    input  logic               imem_ready_i,
    output logic [PC_W-1:0]    pc_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic               valid_o
);

    fetch_state_t       state, state_nxt;
    logic [PC_W-1:0]    fetch_pc, fetch_pc_nxt, fetch_pc_inc, redirect_tgt;
    logic [PC_W-1:0]    addr_nxt, pc_nxt, skid_pc;
    logic [INSTR_W-1:0] instr_nxt, skid_instr;
    logic               valid_nxt, slot_free;
    logic               skid_load, skid_unload, skid_clear, skid_full;

    assign slot_free    = !valid_o || !stall_i;
    assign fetch_pc_inc = fetch_pc + PC_W'(PC_STEP);
    assign redirect_tgt = redirect_pc_i & ~(PC_W'(3));

    fetch_skid_slot #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W)
    ) u_skid (
        .clk        (clk),
        .rst        (rst),
        .load       (skid_load),
        .unload     (skid_unload),
        .clear      (skid_clear),
        .load_pc    (imem_addr_o),
        .load_instr (imem_rdata_i),
        .pc         (skid_pc),
        .instr      (skid_instr),
        .full       (skid_full)
    );

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= BOOT;
        else      state <= state_nxt;
    end

    // next state plus next values of the PC/output registers; redirect first
    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        addr_nxt     = imem_addr_o;
        pc_nxt       = pc_o;
        instr_nxt    = instr_o;
        valid_nxt    = valid_o && stall_i;
        skid_load    = 1'b0;
        skid_unload  = 1'b0;
        skid_clear   = 1'b0;
        if (redirect_i) begin
            valid_nxt    = 1'b0;
            skid_clear   = 1'b1;
            fetch_pc_nxt = redirect_tgt;
            unique case (state)
                FETCH: begin
                    if (imem_ready_i) addr_nxt  = redirect_tgt;
                    else              state_nxt = DRAIN;
                end
                FULL, BOOT: begin
                    addr_nxt  = redirect_tgt;
                    state_nxt = FETCH;
                end
                DRAIN: ;
                default: state_nxt = BOOT;
            endcase
        end else begin
            unique case (state)
                BOOT: begin
                    addr_nxt  = fetch_pc;
                    state_nxt = FETCH;
                end
                FETCH: begin
                    if (imem_ready_i) begin
                        fetch_pc_nxt = fetch_pc_inc;
                        if (slot_free) begin
                            pc_nxt    = imem_addr_o;
                            instr_nxt = imem_rdata_i;
                            valid_nxt = 1'b1;
                            addr_nxt  = fetch_pc_inc;
                        end else begin
                            skid_load = 1'b1;
                            state_nxt = FULL;
                        end
                    end
                end
                FULL: begin
                    if (!stall_i) begin
                        pc_nxt      = skid_pc;
                        instr_nxt   = skid_instr;
                        valid_nxt   = skid_full;
                        skid_unload = 1'b1;
                        addr_nxt    = fetch_pc;
                        state_nxt   = FETCH;
                    end
                end
                DRAIN: begin
                    if (imem_ready_i) begin
                        addr_nxt  = fetch_pc;
                        state_nxt = FETCH;
                    end
                end
                default: state_nxt = BOOT;
            endcase
        end
    end

    // request strobe is a pure function of state
    always_comb begin
        imem_req_o = (state == FETCH) || (state == DRAIN);
    end

    // PC, request address and IF/ID-facing registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc    <= RESET_PC;
            imem_addr_o <= RESET_PC;
            pc_o        <= '0;
            instr_o     <= '0;
            valid_o     <= 1'b0;
        end else begin
            fetch_pc    <= fetch_pc_nxt;
            imem_addr_o <= addr_nxt;
            pc_o        <= pc_nxt;
            instr_o     <= instr_nxt;
            valid_o     <= valid_nxt;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: memory responder with programmable latency and an
// in-order program-stream scoreboard (next consumed pc = last + 4, or the
// aligned redirect target), plus directed scenario checks.
module tb_if_fetch_stage;

    localparam int unsigned PC_W    = 32;
    localparam int unsigned INSTR_W = 32;

    logic               clk = 1'b0;
    logic               rst;
    logic               stall_i, redirect_i, imem_ready_i;
    logic [PC_W-1:0]    redirect_pc_i;
    logic [INSTR_W-1:0] imem_rdata_i;
    logic               imem_req_o, valid_o;
    logic [PC_W-1:0]    imem_addr_o, pc_o;
    logic [INSTR_W-1:0] instr_o;

    logic               rst2, stall2, redir2, ready2;
    logic [PC_W-1:0]    redir_pc2;
    logic [INSTR_W-1:0] rdata2;
    logic               req2, valid2;
    logic [PC_W-1:0]    addr2, pc2;
    logic [INSTR_W-1:0] instr2;

    always #5 clk = ~clk;

    if_fetch_stage #(.PC_W(PC_W), .INSTR_W(INSTR_W), .RESET_PC(32'h0000_0000)) u_dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .redirect_i(redirect_i),
        .redirect_pc_i(redirect_pc_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_rdata_i(imem_rdata_i), .imem_ready_i(imem_ready_i),
        .pc_o(pc_o), .instr_o(instr_o), .valid_o(valid_o)
    );

    if_fetch_stage #(.PC_W(PC_W), .INSTR_W(INSTR_W), .RESET_PC(32'hFFFF_FFF8)) u_dut_wrap (
        .clk(clk), .rst(rst2), .stall_i(stall2), .redirect_i(redir2),
        .redirect_pc_i(redir_pc2), .imem_req_o(req2), .imem_addr_o(addr2),
        .imem_rdata_i(rdata2), .imem_ready_i(ready2),
        .pc_o(pc2), .instr_o(instr2), .valid_o(valid2)
    );

    int          n_checks = 0;
    int          n_pass = 0;
    int          n_consumed = 0;
    logic [31:0] exp_pc;
    int          wait_cnt, cur_lat, fixed_lat;
    bit          rand_lat;
    bit          prev_wait;
    logic [31:0] prev_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    // One clock: called at a negedge, drives inputs, returns at the next negedge.
    task automatic tick(input bit st, input bit rd, input logic [31:0] tgt);
        logic rdy;
        int   nxt_wait;
        rdy = 1'b0;
        if (imem_req_o) begin
            if (wait_cnt == 0) cur_lat = rand_lat ? int'($urandom_range(0, 3)) : fixed_lat;
            rdy = (wait_cnt >= cur_lat);
        end
        if (prev_wait) begin
            n_checks++;
            if (imem_req_o !== 1'b1 || imem_addr_o !== prev_addr)
                $display("FAIL addr_stable: req=%b addr=%h, required req=1 addr=%h", imem_req_o, imem_addr_o, prev_addr);
            else n_pass++;
        end
        prev_wait = imem_req_o && !rdy;
        prev_addr = imem_addr_o;
        nxt_wait  = (imem_req_o && !rdy) ? wait_cnt + 1 : 0;
        if (rd) begin
            exp_pc = tgt & ~32'h3;
        end else if (valid_o && !st) begin
            n_checks++;
            if (pc_o !== exp_pc || instr_o !== mem_word(exp_pc))
                $display("FAIL stream: pc=%h instr=%h, required pc=%h instr=%h", pc_o, instr_o, exp_pc, mem_word(exp_pc));
            else n_pass++;
            n_consumed++;
            exp_pc = exp_pc + 32'd4;
        end
        stall_i       = st;
        redirect_i    = rd;
        redirect_pc_i = tgt;
        imem_ready_i  = rdy;
        imem_rdata_i  = rdy ? mem_word(imem_addr_o) : 32'hDEAD_BEEF;
        rdata2        = mem_word(addr2);
        @(posedge clk);
        wait_cnt = nxt_wait;
        #1;
        if (rd) begin
            n_checks++;
            if (valid_o !== 1'b0) $display("FAIL redirect_bubble: valid=%b, required 0", valid_o);
            else n_pass++;
        end
        @(negedge clk);
    endtask

    // Asserts reset mid-cycle, checks outputs before any clock edge, releases at a negedge.
    task automatic apply_reset(input string tag);
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if (valid_o !== 1'b0 || pc_o !== 32'h0 || instr_o !== 32'h0 || imem_req_o !== 1'b0 || imem_addr_o !== 32'h0)
            $display("FAIL %s: valid=%b pc=%h instr=%h req=%b addr=%h, required all 0",
                     tag, valid_o, pc_o, instr_o, imem_req_o, imem_addr_o);
        else n_pass++;
        stall_i = 1'b0; redirect_i = 1'b0; imem_ready_i = 1'b0;
        wait_cnt = 0; cur_lat = 0; prev_wait = 1'b0; exp_pc = 32'h0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset("reset_values");
    endtask

    task automatic test_zero_wait();
        apply_reset("reset_zero_wait");
        rand_lat = 1'b0; fixed_lat = 0;
        tick(0, 0, 0);
        n_checks++;
        if (valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h0)
            $display("FAIL boot_to_fetch: valid=%b req=%b addr=%h, required 0/1/0", valid_o, imem_req_o, imem_addr_o);
        else n_pass++;
        for (int k = 0; k < 4; k++) begin
            tick(0, 0, 0);
            n_checks++;
            if (valid_o !== 1'b1 || pc_o !== 32'(4 * k) || instr_o !== mem_word(32'(4 * k)))
                $display("FAIL zero_wait_seq: valid=%b pc=%h instr=%h, required 1 pc=%h", valid_o, pc_o, instr_o, 32'(4 * k));
            else n_pass++;
        end
    endtask

    task automatic test_latency();
        int last, pulses;
        apply_reset("reset_latency");
        rand_lat = 1'b0; fixed_lat = 3;
        last = -1; pulses = 0;
        for (int i = 1; i <= 20; i++) begin
            tick(0, 0, 0);
            if (i >= 5 && i <= 8) begin
                n_checks++;
                if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h4)
                    $display("FAIL latency_addr_hold: req=%b addr=%h, required 1 addr=00000004", imem_req_o, imem_addr_o);
                else n_pass++;
            end
            if (valid_o === 1'b1) begin
                pulses++;
                if (last >= 0) begin
                    n_checks++;
                    if (i - last != 4) $display("FAIL latency_spacing: %0d cycles, required 4", i - last);
                    else n_pass++;
                end
                last = i;
            end
        end
        n_checks++;
        if (pulses != 4) $display("FAIL latency_pulses: %0d valid cycles, required 4", pulses);
        else n_pass++;
    endtask

    task automatic test_stall();
        apply_reset("reset_stall");
        rand_lat = 1'b0; fixed_lat = 0;
        for (int i = 0; i < 4; i++) tick(0, 0, 0);
        n_checks++;
        if (valid_o !== 1'b1 || pc_o !== 32'h8) $display("FAIL stall_setup: valid=%b pc=%h, required 1 pc=00000008", valid_o, pc_o);
        else n_pass++;
        for (int s = 0; s < 5; s++) begin
            tick(1, 0, 0);
            n_checks++;
            if (valid_o !== 1'b1 || pc_o !== 32'h8 || instr_o !== mem_word(32'h8) || imem_req_o !== 1'b0)
                $display("FAIL stall_hold: valid=%b pc=%h req=%b, required 1 pc=00000008 req=0", valid_o, pc_o, imem_req_o);
            else n_pass++;
        end
        tick(0, 0, 0);
        n_checks++;
        if (valid_o !== 1'b1 || pc_o !== 32'hC || instr_o !== mem_word(32'hC) || imem_req_o !== 1'b1 || imem_addr_o !== 32'h10)
            $display("FAIL skid_unload: valid=%b pc=%h req=%b addr=%h, required 1 pc=0000000c req=1 addr=00000010",
                     valid_o, pc_o, imem_req_o, imem_addr_o);
        else n_pass++;
        tick(0, 0, 0);
        n_checks++;
        if (valid_o !== 1'b1 || pc_o !== 32'h10) $display("FAIL after_skid: valid=%b pc=%h, required 1 pc=00000010", valid_o, pc_o);
        else n_pass++;
    endtask

    task automatic test_redirect();
        bit found;
        apply_reset("reset_redirect");
        rand_lat = 1'b0; fixed_lat = 0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick(0, 0, 0);
            if (imem_req_o === 1'b1 && imem_addr_o === 32'h14) found = 1'b1;
        end
        n_checks++;
        if (!found) $display("FAIL redirect_setup: request to 00000014 not seen within 20 cycles, required seen");
        else n_pass++;
        fixed_lat = 3;
        tick(0, 0, 0);
        tick(0, 1, 32'h100);
        fixed_lat = 0;
        n_checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h14)
            $display("FAIL drain_hold: req=%b addr=%h, required 1 addr=00000014", imem_req_o, imem_addr_o);
        else n_pass++;
        tick(0, 0, 0);
        n_checks++;
        if (valid_o !== 1'b0 || imem_addr_o !== 32'h14) $display("FAIL drain_wait: valid=%b addr=%h, required 0 addr=00000014", valid_o, imem_addr_o);
        else n_pass++;
        tick(0, 0, 0);
        n_checks++;
        if (valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h100)
            $display("FAIL drain_discard: valid=%b req=%b addr=%h, required 0 1 addr=00000100", valid_o, imem_req_o, imem_addr_o);
        else n_pass++;
        tick(0, 0, 0);
        n_checks++;
        if (valid_o !== 1'b1 || pc_o !== 32'h100 || instr_o !== mem_word(32'h100))
            $display("FAIL redirect_target: valid=%b pc=%h, required 1 pc=00000100", valid_o, pc_o);
        else n_pass++;
    endtask

    task automatic test_redirect_stall();
        tick(1, 1, 32'h203);
        n_checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h200)
            $display("FAIL redir_stall_addr: req=%b addr=%h, required 1 addr=00000200", imem_req_o, imem_addr_o);
        else n_pass++;
        tick(0, 0, 0);
        n_checks++;
        if (valid_o !== 1'b1 || pc_o !== 32'h200) $display("FAIL redir_stall_pc: valid=%b pc=%h, required 1 pc=00000200", valid_o, pc_o);
        else n_pass++;
    endtask

    task automatic test_wrap();
        logic [31:0] pcs[$];
        logic [31:0] e;
        rst2 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick(0, 0, 0);
            if (valid2 === 1'b1) begin
                pcs.push_back(pc2);
                n_checks++;
                if (instr2 !== mem_word(pc2) || req2 !== 1'b1)
                    $display("FAIL wrap_instr: instr=%h req=%b, required instr=%h req=1", instr2, req2, mem_word(pc2));
                else n_pass++;
            end
        end
        e = 32'hFFFF_FFF8;
        for (int j = 0; j < 3; j++) begin
            n_checks++;
            if (j >= pcs.size()) $display("FAIL wrap_seq[%0d]: only %0d presented, required >= 3", j, pcs.size());
            else if (pcs[j] !== e) $display("FAIL wrap_seq[%0d]: pc=%h, required %h", j, pcs[j], e);
            else n_pass++;
            e = e + 32'd4;
        end
    endtask

    task automatic test_reset_in_drain();
        bit seen;
        apply_reset("reset_pre_drain");
        rand_lat = 1'b0; fixed_lat = 0;
        for (int i = 0; i < 3; i++) tick(0, 0, 0);
        fixed_lat = 3;
        tick(0, 0, 0);
        tick(0, 1, 32'h40);
        n_checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h8)
            $display("FAIL drain_setup: req=%b addr=%h, required 1 addr=00000008", imem_req_o, imem_addr_o);
        else n_pass++;
        apply_reset("reset_in_drain");
        rand_lat = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            tick(0, 0, 0);
            if (valid_o === 1'b1) begin
                seen = 1'b1;
                n_checks++;
                if (pc_o !== 32'h0 || instr_o !== mem_word(32'h0))
                    $display("FAIL restart_first: pc=%h instr=%h, required pc=00000000 instr=%h", pc_o, instr_o, mem_word(32'h0));
                else n_pass++;
            end
        end
        n_checks++;
        if (!seen) $display("FAIL restart_timeout: no valid within 12 cycles, required one");
        else n_pass++;
        rand_lat = 1'b0;
    endtask

    task automatic test_random();
        int c0;
        rand_lat = 1'b1;
        c0 = n_consumed;
        for (int i = 0; i < 400; i++)
            tick($urandom_range(0, 3) == 0, $urandom_range(0, 24) == 0, $urandom);
        n_checks++;
        if (n_consumed - c0 <= 40) $display("FAIL random_progress: %0d consumed, required > 40", n_consumed - c0);
        else n_pass++;
        rand_lat = 1'b0;
    endtask

    initial begin
        rst = 1'b0; rst2 = 1'b0;
        stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
        imem_ready_i = 1'b0; imem_rdata_i = '0;
        stall2 = 1'b0; redir2 = 1'b0; redir_pc2 = '0; ready2 = 1'b1; rdata2 = '0;
        wait_cnt = 0; cur_lat = 0; fixed_lat = 0; rand_lat = 1'b0;
        prev_wait = 1'b0; prev_addr = '0; exp_pc = '0;
        @(negedge clk);
        test_reset();
        test_zero_wait();
        test_latency();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_wrap();
        test_reset_in_drain();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
